bus_op_sequencer: RTL and testbench

- Parametrised successor to the four-register tri-state bus datapath.
- Holds NREGS general registers of WIDTH bits, two adder operand latches (OPA, OPB) and one shared internal data bus.
- A built-in sequencer runs whole register-transfer operations (LOAD, MOVE, ADD, SUB) from a single valid/ready command, replacing hand-driven enable/load strobes.
- Sits between the control unit and the register datapath.

---
 rtl/bus_seq_pkg.sv | 25 ++
 rtl/bus_regfile.sv | 41 ++++
 rtl/bus_op_sequencer.sv | 146 ++++++++++++++
 tb/tb_bus_op_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/bus_seq_pkg.sv
// Shared opcode, state encoding and operand-usage helpers for the bus operation sequencer.
package bus_seq_pkg;

  localparam logic [1:0] OP_LOAD = 2'd0;
  localparam logic [1:0] OP_MOVE = 2'd1;
  localparam logic [1:0] OP_ADD  = 2'd2;
  localparam logic [1:0] OP_SUB  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD_A = 2'd1,
    ST_RD_B = 2'd2,
    ST_WRBK = 2'd3
  } seqState_t;

  // Which source operands an opcode actually reads (drives index range checking)
  function automatic logic usesSrc1(input logic [1:0] op);
    return op != OP_LOAD;
  endfunction

  function automatic logic usesSrc2(input logic [1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/bus_regfile.sv
// NREGS x WIDTH register file: one synchronous write port, bus and debug combinational read ports.
module bus_regfile #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREGS = 4,
  parameter int unsigned IDX_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wrEn,
  input  logic [IDX_W-1:0] wrIdx,
  input  logic [WIDTH-1:0] wrData,
  input  logic [IDX_W-1:0] busIdx,
  output logic [WIDTH-1:0] busData,
  input  logic [IDX_W-1:0] dbgIdx,
  output logic [WIDTH-1:0] dbgData
);

  logic [WIDTH-1:0] regs [NREGS];

  // Index compare per entry keeps an out-of-range write a no-op
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
    end else if (wrEn) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        if (wrIdx == IDX_W'(i)) regs[i] <= wrData;
      end
    end
  end

  // Out-of-range reads return zero
  always_comb begin
    busData = '0;
    dbgData = '0;
    for (int i = 0; i < int'(NREGS); i++) begin
      if (busIdx == IDX_W'(i)) busData = regs[i];
      if (dbgIdx == IDX_W'(i)) dbgData = regs[i];
    end
  end

endmodule

// File: rtl/bus_op_sequencer.sv
// Register-transfer sequencer: runs LOAD/MOVE/ADD/SUB over a shared internal bus from one command.
module bus_op_sequencer
  import bus_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREGS = 4,
  parameter int unsigned IDX_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [IDX_W-1:0] cmd_dst,
  input  logic [IDX_W-1:0] cmd_src1,
  input  logic [IDX_W-1:0] cmd_src2,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             done,
  output logic             err,
  output logic             carry,
  output logic             busy,
  output logic [WIDTH-1:0] bus_mon,
  input  logic [IDX_W-1:0] rd_sel,
  output logic [WIDTH-1:0] rd_data
);

  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned SUM_W = WIDTH + 1;

  seqState_t        state;
  logic [1:0]       opQ;
  logic [IDX_W-1:0] dstQ;
  logic [IDX_W-1:0] src1Q;
  logic [IDX_W-1:0] src2Q;
  logic [WIDTH-1:0] dataQ;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;

  logic [WIDTH-1:0] busVal;
  logic [WIDTH-1:0] regBusData;
  logic [IDX_W-1:0] busIdx;
  logic [SUM_W-1:0] sumFull;
  logic [SUM_W-1:0] diffFull;
  logic [SUM_W-1:0] arithFull;
  logic             cmdBad;
  logic             regWrEn;

  // Extra bit on the compare so NREGS == 2**IDX_W still works
  function automatic logic inRange(input logic [IDX_W-1:0] idx);
    return {1'b0, idx} < CNT_W'(NREGS);
  endfunction

  assign cmdBad = !inRange(dstQ)
               || (usesSrc1(opQ) && !inRange(src1Q))
               || (usesSrc2(opQ) && !inRange(src2Q));

  assign busIdx    = (state == ST_RD_B) ? src2Q : src1Q;
  assign sumFull   = {1'b0, opA} + {1'b0, opB};
  assign diffFull  = {1'b0, opA} - {1'b0, opB};
  assign arithFull = (opQ == OP_SUB) ? diffFull : sumFull;
  assign regWrEn   = (state == ST_WRBK) && !cmdBad;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign bus_mon   = busVal;

  // Single bus driver per state; floats to zero when idle
  always_comb begin
    busVal = '0;
    unique case (state)
      ST_IDLE: busVal = '0;
      ST_RD_A: busVal = regBusData;
      ST_RD_B: busVal = regBusData;
      ST_WRBK: begin
        unique case (opQ)
          OP_LOAD: busVal = dataQ;
          OP_MOVE: busVal = opA;
          default: busVal = arithFull[WIDTH-1:0];
        endcase
      end
    endcase
  end

  bus_regfile #(
    .WIDTH(WIDTH),
    .NREGS(NREGS),
    .IDX_W(IDX_W)
  ) u_regfile (
    .clock  (clock),
    .reset  (reset),
    .wrEn   (regWrEn),
    .wrIdx  (dstQ),
    .wrData (busVal),
    .busIdx (busIdx),
    .busData(regBusData),
    .dbgIdx (rd_sel),
    .dbgData(rd_data)
  );

  // Sequencer: one cycle per state, done/err pulse in the cycle after WRBK
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= ST_IDLE;
      opQ   <= OP_LOAD;
      dstQ  <= '0;
      src1Q <= '0;
      src2Q <= '0;
      dataQ <= '0;
      opA   <= '0;
      opB   <= '0;
      carry <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            opQ   <= cmd_op;
            dstQ  <= cmd_dst;
            src1Q <= cmd_src1;
            src2Q <= cmd_src2;
            dataQ <= cmd_data;
            state <= (cmd_op == OP_LOAD) ? ST_WRBK : ST_RD_A;
          end
        end
        ST_RD_A: begin
          opA   <= busVal;
          state <= (opQ == OP_MOVE) ? ST_WRBK : ST_RD_B;
        end
        ST_RD_B: begin
          opB   <= busVal;
          state <= ST_WRBK;
        end
        ST_WRBK: begin
          done <= 1'b1;
          err  <= cmdBad;
          if (!cmdBad && usesSrc2(opQ)) carry <= arithFull[WIDTH];
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_op_sequencer.sv
// Directed bench: a 4-register and a 3-register sequencer share one command stream.
module tb_bus_op_sequencer;
  import bus_seq_pkg::*;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned IDX_W = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             cmdValid;
  logic [1:0]       cmdOp;
  logic [IDX_W-1:0] cmdDst, cmdSrc1, cmdSrc2, rdSel;
  logic [WIDTH-1:0] cmdData;

  logic             ready4, done4, err4, carry4, busy4;
  logic [WIDTH-1:0] busMon4, rdData4;
  logic             ready3, done3, err3, carry3, busy3;
  logic [WIDTH-1:0] busMon3, rdData3;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  bus_op_sequencer #(.WIDTH(WIDTH), .NREGS(4), .IDX_W(IDX_W)) dut4 (
    .clock(clock), .reset(reset), .cmd_valid(cmdValid), .cmd_ready(ready4),
    .cmd_op(cmdOp), .cmd_dst(cmdDst), .cmd_src1(cmdSrc1), .cmd_src2(cmdSrc2),
    .cmd_data(cmdData), .done(done4), .err(err4), .carry(carry4), .busy(busy4),
    .bus_mon(busMon4), .rd_sel(rdSel), .rd_data(rdData4)
  );

  bus_op_sequencer #(.WIDTH(WIDTH), .NREGS(3), .IDX_W(IDX_W)) dut3 (
    .clock(clock), .reset(reset), .cmd_valid(cmdValid), .cmd_ready(ready3),
    .cmd_op(cmdOp), .cmd_dst(cmdDst), .cmd_src1(cmdSrc1), .cmd_src2(cmdSrc2),
    .cmd_data(cmdData), .done(done3), .err(err3), .carry(carry3), .busy(busy3),
    .bus_mon(busMon3), .rd_sel(rdSel), .rd_data(rdData3)
  );

  typedef struct {
    logic [1:0]       op;
    logic [IDX_W-1:0] dst;
    logic [IDX_W-1:0] s1;
    logic [IDX_W-1:0] s2;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] expVal;
    logic             expCarry;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic errFor(input logic [1:0] op, input logic [IDX_W-1:0] dst,
                                  input logic [IDX_W-1:0] s1, input logic [IDX_W-1:0] s2,
                                  input int n);
    return (int'(dst) >= n) || ((op != OP_LOAD) && (int'(s1) >= n))
        || ((op == OP_ADD || op == OP_SUB) && (int'(s2) >= n));
  endfunction

  task automatic setRd(input logic [IDX_W-1:0] idx);
    rdSel = idx;
    #1;
  endtask

  // Issue one command, then bound the wait for done and check the completion cycle
  task automatic issue(input logic [1:0] op, input logic [IDX_W-1:0] dst,
                       input logic [IDX_W-1:0] s1, input logic [IDX_W-1:0] s2,
                       input logic [WIDTH-1:0] data);
    int lat;
    int expLat;
    expLat = (op == OP_LOAD) ? 1 : (op == OP_MOVE) ? 2 : 3;
    @(negedge clock);
    cmdOp = op; cmdDst = dst; cmdSrc1 = s1; cmdSrc2 = s2; cmdData = data;
    cmdValid = 1'b1;
    chk("ready_before_accept", 32'(ready4), 32'd1);
    @(posedge clock); #1;
    cmdValid = 1'b0;
    lat = 0;
    while (!done4 && lat < 8) begin
      @(posedge clock); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(expLat));
    chk("done4", 32'(done4), 32'd1);
    chk("err4", 32'(err4), 32'(errFor(op, dst, s1, s2, 4)));
    chk("done3", 32'(done3), 32'd1);
    chk("err3", 32'(err3), 32'(errFor(op, dst, s1, s2, 3)));
    chk("ready_in_done", 32'(ready4), 32'd1);
    chk("busy_in_done", 32'({busy4, busy3}), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{OP_LOAD, 4'd0, 4'd0, 4'd0, 16'h004F, 16'h004F, 1'b0};
    vecs[1]  = '{OP_LOAD, 4'd1, 4'd0, 4'd0, 16'h003F, 16'h003F, 1'b0};
    vecs[2]  = '{OP_LOAD, 4'd2, 4'd0, 4'd0, 16'h000F, 16'h000F, 1'b0};
    vecs[3]  = '{OP_LOAD, 4'd3, 4'd0, 4'd0, 16'h0028, 16'h0028, 1'b0};
    vecs[4]  = '{OP_ADD,  4'd0, 4'd1, 4'd0, 16'hDEAD, 16'h008E, 1'b0};
    vecs[5]  = '{OP_ADD,  4'd2, 4'd1, 4'd3, 16'h0000, 16'h0067, 1'b0};
    vecs[6]  = '{OP_ADD,  4'd3, 4'd3, 4'd2, 16'h0000, 16'h008F, 1'b0};
    vecs[7]  = '{OP_LOAD, 4'd1, 4'd0, 4'd0, 16'hFFFF, 16'hFFFF, 1'b0};
    vecs[8]  = '{OP_LOAD, 4'd2, 4'd0, 4'd0, 16'h0001, 16'h0001, 1'b0};
    vecs[9]  = '{OP_ADD,  4'd0, 4'd1, 4'd2, 16'h0000, 16'h0000, 1'b1};
    vecs[10] = '{OP_SUB,  4'd3, 4'd2, 4'd1, 16'h0000, 16'h0002, 1'b1};
    vecs[11] = '{OP_LOAD, 4'd0, 4'd0, 4'd0, 16'h1234, 16'h1234, 1'b1};
    vecs[12] = '{OP_SUB,  4'd1, 4'd1, 4'd1, 16'h0000, 16'h0000, 1'b0};
    vecs[13] = '{OP_SUB,  4'd2, 4'd1, 4'd3, 16'h0000, 16'hFFFE, 1'b1};
    vecs[14] = '{OP_MOVE, 4'd5, 4'd0, 4'd0, 16'h0000, 16'h0000, 1'b1};

    reset = 1'b0; cmdValid = 1'b0; cmdOp = OP_LOAD;
    cmdDst = '0; cmdSrc1 = '0; cmdSrc2 = '0; cmdData = '0; rdSel = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ready", 32'({ready4, ready3}), 32'h3);
    chk("rst_busy", 32'({busy4, busy3}), 32'h0);
    chk("rst_done_err", 32'({done4, err4, done3, err3}), 32'h0);
    chk("rst_carry", 32'({carry4, carry3}), 32'h0);
    chk("rst_bus_mon", 32'({busMon4, busMon3}), 32'h0);
    for (int i = 0; i < 4; i++) begin
      setRd(IDX_W'(i));
      chk("rst_reg", 32'(rdData4), 32'h0);
    end
    reset = 1'b1;

    for (int v = 0; v < 15; v++) begin
      issue(vecs[v].op, vecs[v].dst, vecs[v].s1, vecs[v].s2, vecs[v].data);
      setRd(vecs[v].dst);
      chk($sformatf("vec%0d_result", v), 32'(rdData4), 32'(vecs[v].expVal));
      chk($sformatf("vec%0d_carry", v), 32'(carry4), 32'(vecs[v].expCarry));
    end

    // MOVE R2=R0 while scrambling cmd_* during the busy window
    @(negedge clock);
    cmdOp = OP_MOVE; cmdDst = 4'd2; cmdSrc1 = 4'd0; cmdSrc2 = 4'd0; cmdValid = 1'b1;
    @(posedge clock); #1;
    cmdValid = 1'b0; cmdOp = OP_LOAD; cmdDst = 4'd1; cmdSrc1 = 4'd3; cmdData = 16'hDEAD;
    chk("move_rd_a_bus", 32'(busMon4), 32'h1234);
    chk("move_rd_a_busy", 32'({busy4, ready4, done4}), 32'b100);
    @(posedge clock); #1;
    chk("move_wrbk_bus", 32'(busMon4), 32'h1234);
    chk("move_wrbk_done", 32'(done4), 32'd0);
    @(posedge clock); #1;
    chk("move_done", 32'({done4, err4, ready4}), 32'b101);
    setRd(4'd2);
    chk("move_r2", 32'(rdData4), 32'h1234);
    setRd(4'd1);
    chk("move_r1_untouched", 32'(rdData4), 32'h0000);
    chk("move_carry_kept", 32'(carry4), 32'd1);

    // Reset during RD_B drops the ADD
    @(negedge clock);
    cmdOp = OP_ADD; cmdDst = 4'd0; cmdSrc1 = 4'd1; cmdSrc2 = 4'd2; cmdValid = 1'b1;
    @(posedge clock); #1;
    cmdValid = 1'b0;
    @(posedge clock); #1;
    chk("pre_reset_no_done", 32'(done4), 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("midrst_done", 32'({done4, done3}), 32'h0);
    chk("midrst_busy", 32'({busy4, busy3}), 32'h0);
    chk("midrst_carry", 32'(carry4), 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("postrst_ready", 32'(ready4), 32'd1);
    chk("postrst_done", 32'(done4), 32'd0);
    for (int i = 0; i < 4; i++) begin
      setRd(IDX_W'(i));
      chk("postrst_reg", 32'(rdData4), 32'h0);
    end

    // Out-of-range destination on the 3-register build
    issue(OP_LOAD, 4'd0, 4'd0, 4'd0, 16'h0005);
    issue(OP_LOAD, 4'd1, 4'd0, 4'd0, 16'h0006);
    issue(OP_ADD, 4'd3, 4'd0, 4'd1, 16'h0000);
    setRd(4'd0); chk("n3_r0", 32'(rdData3), 32'h0005);
    setRd(4'd1); chk("n3_r1", 32'(rdData3), 32'h0006);
    setRd(4'd2); chk("n3_r2", 32'(rdData3), 32'h0000);
    setRd(4'd3); chk("n3_r3_oob", 32'(rdData3), 32'h0000);
    chk("n4_r3", 32'(rdData4), 32'h000B);
    chk("n3_carry", 32'(carry3), 32'd0);
    issue(OP_LOAD, 4'd2, 4'd0, 4'd0, 16'h00AA);
    setRd(4'd2); chk("n3_r2_load", 32'(rdData3), 32'h00AA);
    chk("n3_idle_bus", 32'(busMon3), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
